// File: rtl/addsub_digit_serial_if.sv
// Request/result bundle for the digit-serial adder/subtractor.
// The master issues operations; the slave (the datapath) returns status and results.
interface addsub_digit_serial_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mode;
   logic             sat;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;

   modport master (
      output start, a, b, mode, sat,
      input  busy, done, result, carry_out, overflow
   );

   modport slave (
      input  start, a, b, mode, sat,
      output busy, done, result, carry_out, overflow
   );
endinterface

// File: rtl/addsub_digit_serial.sv
// Digit-serial two's-complement add/sub: one DIGIT-wide ripple slice reused over
// WIDTH/DIGIT cycles, with start/busy/done handshake, overflow flag and optional saturation.
module addsub_digit_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   addsub_digit_serial_if.slave bus
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

   logic [1:0]       state_q,     state_d;
   logic [WIDTH-1:0] a_q,         a_d;
   logic [WIDTH-1:0] b_q,         b_d;
   logic             a_msb_q,     a_msb_d;
   logic             sat_q,       sat_d;
   logic             carry_q,     carry_d;
   logic [CW-1:0]    cnt_q,       cnt_d;
   logic [WIDTH-1:0] sum_q,       sum_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q,  overflow_d;

   logic [DIGIT:0]   chain;
   logic [DIGIT-1:0] digit_sum;
   logic             c_msb;
   logic             c_out;
   logic             ovf;
   logic             last_digit;
   logic [WIDTH-1:0] full_sum;

   // Operands shift right one digit per RUN cycle, so the slice always sees bits [DIGIT-1:0].
   always_comb begin
      chain     = '0;
      digit_sum = '0;
      chain[0]  = carry_q;
      for (int i = 0; i < DIGIT; i++) begin
         digit_sum[i] = a_q[i] ^ b_q[i] ^ chain[i];
         chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
      end
   end

   assign c_msb      = chain[DIGIT-1];
   assign c_out      = chain[DIGIT];
   assign ovf        = c_msb ^ c_out;
   assign last_digit = (cnt_q == CW'(NDIG - 1));
   // Sum digits enter at the top, so after NDIG shifts the LSB digit sits at the bottom.
   assign full_sum   = (sum_q >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));

   // NOTE: every _d gets a default equal to its _q before any branch, so no path
   // leaves a combinational output unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      a_msb_d     = a_msb_q;
      sat_d       = sat_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;

      case (state_q)
         S_RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = c_out;
            sum_d   = full_sum;
            if (last_digit) begin
               state_d     = S_DONE;
               carry_out_d = c_out;
               overflow_d  = ovf;
               if (sat_q && ovf) begin
                  result_d = a_msb_q ? SAT_MIN : SAT_MAX;
               end else begin
                  result_d = full_sum;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
            if (bus.start) begin
               state_d = S_RUN;
               a_d     = bus.a;
               b_d     = bus.b ^ {WIDTH{bus.mode}};
               a_msb_d = bus.a[WIDTH-1];
               sat_d   = bus.sat;
               carry_d = bus.mode;
               cnt_d   = '0;
               sum_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the operand and shift registers are reset too, not just the FSM,
         // so an aborted operation leaves no stale data behind.
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         a_msb_q     <= 1'b0;
         sat_q       <= 1'b0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
         sum_q       <= '0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         a_msb_q     <= a_msb_d;
         sat_q       <= sat_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.result    = result_q;
   assign bus.carry_out = carry_out_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_addsub_digit_serial.sv
// Directed bench for addsub_digit_serial: a 16-bit/4-bit-digit instance and an
// 8-bit single-digit instance share clock and reset.
module tb_addsub_digit_serial;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   addsub_digit_serial_if #(.WIDTH(16)) b16 ();
   addsub_digit_serial_if #(.WIDTH(8))  b8 ();

   addsub_digit_serial #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(b16.slave));
   addsub_digit_serial #(.WIDTH(8),  .DIGIT(8)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

   int checks   = 0;
   int failures = 0;
   bit use8     = 1'b0;

   logic        cur_busy, cur_done, cur_cout, cur_ovf;
   logic [15:0] cur_res;

   always_comb begin
      if (use8) begin
         cur_busy = b8.busy;
         cur_done = b8.done;
         cur_cout = b8.carry_out;
         cur_ovf  = b8.overflow;
         cur_res  = {8'h00, b8.result};
      end else begin
         cur_busy = b16.busy;
         cur_done = b16.done;
         cur_cout = b16.carry_out;
         cur_ovf  = b16.overflow;
         cur_res  = b16.result;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic st);
      if (use8) begin
         b8.start = s; b8.a = a[7:0]; b8.b = b[7:0]; b8.mode = m; b8.sat = st;
      end else begin
         b16.start = s; b16.a = a; b16.b = b; b16.mode = m; b16.sat = st;
      end
   endtask

   // Called just after the start-driving negedge; returns at the negedge where done is seen.
   task automatic wait_done(input string tag, input int exp_lat, input bit noise,
                            input logic [15:0] prev_res);
      int n = 0;
      int busy_n = 0;
      int overlap = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) check({tag, "_held"}, cur_res, prev_res);
         if (noise && n < exp_lat - 1) drive(1'b1, 16'h5555, 16'h1111, 1'b1, 1'b1);
         else                          drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
         if (cur_busy) busy_n++;
         if (cur_busy && cur_done) overlap++;
      end while (!cur_done && n < 40);
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
      check({tag, "_busy_done_overlap"}, overlap, 0);
   endtask

   task automatic check_result(input string tag, input logic [15:0] r, input logic c, input logic o);
      check({tag, "_result"}, cur_res, r);
      check({tag, "_carry_out"}, cur_cout, c);
      check({tag, "_overflow"}, cur_ovf, o);
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic m, input logic st, input logic [15:0] exp_r,
                         input logic exp_c, input logic exp_o, input int exp_lat,
                         input logic [15:0] prev_res);
      @(negedge clk);
      drive(1'b1, a, b, m, st);
      wait_done(tag, exp_lat, 1'b0, prev_res);
      check_result(tag, exp_r, exp_c, exp_o);
      @(negedge clk);
      check({tag, "_done_pulse"}, cur_done, 1'b0);
      check({tag, "_idle_busy"}, cur_busy, 1'b0);
      check({tag, "_result_hold"}, cur_res, exp_r);
   endtask

   initial begin
      int done_seen;
      b16.start = 1'b0; b16.a = '0; b16.b = '0; b16.mode = 1'b0; b16.sat = 1'b0;
      b8.start  = 1'b0; b8.a  = '0; b8.b  = '0; b8.mode  = 1'b0; b8.sat  = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_busy", b16.busy, 1'b0);
      check("reset_done", b16.done, 1'b0);
      check("reset_result", b16.result, 16'h0000);
      check("reset_carry_out", b16.carry_out, 1'b0);
      check("reset_overflow", b16.overflow, 1'b0);
      check("reset8_result", b8.result, 8'h00);
      rst = 1'b0;

      use8 = 1'b0;
      run_op("add",       16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 5, 16'h0000);
      run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 5, 16'h2233);
      run_op("sub_pos",   16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 5, 16'hFFFE);
      run_op("ovf_wrap",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 5, 16'h0002);
      run_op("ovf_satmax",16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 5, 16'h8000);
      run_op("ovf_satmin",16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 5, 16'h7FFF);

      // Abort on the second RUN cycle; outputs still hold the saturated result beforehand.
      @(negedge clk);
      drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      check("abort_prev_result", cur_res, 16'h8000);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", cur_busy, 1'b0);
      check("abort_done", cur_done, 1'b0);
      check("abort_result", cur_res, 16'h0000);
      check("abort_carry_out", cur_cout, 1'b0);
      check("abort_overflow", cur_ovf, 1'b0);
      done_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (cur_done || cur_busy) done_seen++;
      end
      check("abort_no_done", done_seen, 0);

      // Starts during RUN are ignored; start held into DONE chains the next operation.
      @(negedge clk);
      drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_done("hs_first", 5, 1'b1, 16'h0000);
      check_result("hs_first", 16'h0002, 1'b0, 1'b0);
      drive(1'b1, 16'h00FF, 16'h0F01, 1'b0, 1'b0);
      wait_done("hs_chain", 5, 1'b0, 16'h0002);
      check_result("hs_chain", 16'h1000, 1'b0, 1'b0);
      @(negedge clk);
      check("hs_chain_done_pulse", cur_done, 1'b0);

      use8 = 1'b1;
      run_op("n1_add",    16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 2, 16'h0000);
      run_op("n1_satmax", 16'h007F, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b0, 1'b1, 2, 16'h0000);
      run_op("n1_sub",    16'h0010, 16'h0003, 1'b1, 1'b0, 16'h000D, 1'b1, 1'b0, 2, 16'h007F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
